// File: rtl/toa_hit_assembler.sv
// TOA hit assembler: merges fine code and coarse count into a
// linear timestamp and buffers it for valid/ready readout.
module toa_hit_assembler #(
  parameter int CW       = 10,
  parameter int DEPTH    = 4,
  parameter int DEAD_CYC = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hit_strobe,
  input  logic [6:0]    fine_code,
  input  logic [CW-1:0] coarse_cnt,
  input  logic [2:0]    level,
  output logic [CW+6:0] toa_data,
  output logic          toa_err,
  output logic          toa_valid,
  input  logic          toa_ready,
  output logic [15:0]   hit_cnt,
  output logic [7:0]    ovf_cnt,
  output logic          busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 2;
  localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam int EW = CW + 8;

  logic [DW-1:0]   dead_q;
  logic            s1_v;
  logic [6:0]      s1_fine;
  logic [CW-1:0]   s1_coarse;
  logic            s1_lvl_ok;
  logic            s2_v;
  logic [EW-1:0]   s2_ent;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [OW-1:0]   occ;
  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic [5:0]      pos;
  logic            bad;
  logic [6:0]      fine_lin;
  logic [CW+6:0]   toa_next;

  assign busy = (dead_q != '0);

  // Entries still in the pipeline count against capacity so that
  // every accepted hit is guaranteed a FIFO slot.
  assign occ = OW'(count) + OW'(s1_v) + OW'(s2_v);
  assign full = (occ >= OW'(DEPTH));
  assign accept = hit_strobe & ~busy & ~full;

  assign push = s2_v;
  assign pop = toa_valid & toa_ready;
  assign toa_valid = (count != '0);
  assign {toa_err, toa_data} = mem[rd_ptr];

  // Fine code linearisation and timestamp arithmetic (coarse*126)
  always_comb begin
    pos = s1_fine[5:0];
    bad = (pos == 6'd63) | ~s1_lvl_ok;
    fine_lin = '0;
    if (!bad)
      fine_lin = s1_fine[6] ? (7'd63 + {1'b0, pos}) : {1'b0, pos};
    toa_next = {s1_coarse, 7'b0}
             - {6'b0, s1_coarse, 1'b0}
             + {{CW{1'b0}}, fine_lin};
  end

  // Dead-time counter: reload on accept, count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dead_q <= '0;
    else if (accept)
      dead_q <= DW'(DEAD_CYC);
    else if (dead_q != '0)
      dead_q <= dead_q - 1'b1;
  end

  // Stage 1: capture encoder outputs at the accepted strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_fine   <= '0;
      s1_coarse <= '0;
      s1_lvl_ok <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_fine   <= fine_code;
        s1_coarse <= coarse_cnt;
        s1_lvl_ok <= (level != 3'd0) & ~level[2];
      end
    end
  end

  // Stage 2: register the assembled {err, toa} entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_ent <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v)
        s2_ent <= {bad, toa_next};
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s2_ent;
        wr_ptr <= AW'((32'(wr_ptr) + 1) % DEPTH);
      end
      if (pop)
        rd_ptr <= AW'((32'(rd_ptr) + 1) % DEPTH);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating accepted-hit and dropped-hit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
      ovf_cnt <= '0;
    end else if (hit_strobe) begin
      if (accept) begin
        if (hit_cnt != 16'hFFFF)
          hit_cnt <= hit_cnt + 1'b1;
      end else if (ovf_cnt != 8'hFF) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_toa_hit_assembler.sv
// Self-checking bench for toa_hit_assembler: directed scenarios
// plus randomized strobes against a timestamp reference model.
module tb_toa_hit_assembler;

  localparam int CW = 10;
  localparam int DEPTH = 4;
  localparam int DEAD_CYC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hit_strobe;
  logic [6:0]    fine_code;
  logic [CW-1:0] coarse_cnt;
  logic [2:0]    level;
  logic [CW+6:0] toa_data;
  logic          toa_err;
  logic          toa_valid;
  logic          toa_ready;
  logic [15:0]   hit_cnt;
  logic [7:0]    ovf_cnt;
  logic          busy;

  int n_tests = 0;
  int n_fail = 0;

  toa_hit_assembler #(
    .CW(CW), .DEPTH(DEPTH), .DEAD_CYC(DEAD_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hit_strobe(hit_strobe), .fine_code(fine_code),
    .coarse_cnt(coarse_cnt), .level(level),
    .toa_data(toa_data), .toa_err(toa_err),
    .toa_valid(toa_valid), .toa_ready(toa_ready),
    .hit_cnt(hit_cnt), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: {err, timestamp} from the encoder rules in plain ints
  function automatic logic [CW+7:0] ref_toa(
    input logic [6:0] f, input int c, input int l);
    int p;
    int fl;
    bit e;
    p = int'(f[5:0]);
    e = (p == 63) || (l < 1) || (l > 3);
    fl = e ? 0 : (f[6] ? 63 + p : p);
    return {e, (CW+7)'(c * 126 + fl)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    hit_strobe = 1'b0;
    fine_code = '0;
    coarse_cnt = '0;
    level = 3'd1;
    toa_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [6:0] f, input int c,
                        input int l);
    hit_strobe = 1'b1;
    fine_code = f;
    coarse_cnt = CW'(c);
    level = 3'(l);
    @(negedge clk);
    hit_strobe = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (toa_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hit_strobe = 1'b0;
    toa_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({toa_valid, toa_err, toa_data, hit_cnt, ovf_cnt, busy}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b e=%b d=%0d h=%0d o=%0d b=%b want all 0",
               toa_valid, toa_err, toa_data, hit_cnt, ovf_cnt, busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    strobe(7'b0_000101, 3, 1);
    @(negedge clk);
    n_tests++;
    if (toa_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: valid=%b want 0", toa_valid);
    end
    @(negedge clk);
    n_tests++;
    if (toa_valid !== 1'b1 || toa_data !== 17'd383 ||
        toa_err !== 1'b0 || hit_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_data: v=%b d=%0d e=%b h=%0d want 1 383 0 1",
               toa_valid, toa_data, toa_err, hit_cnt);
    end
    @(negedge clk);
    n_tests++;
    if (toa_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse: valid=%b want 0", toa_valid);
    end
  endtask

  task automatic test_max();
    bit ok;
    do_reset();
    strobe(7'b1_111110, 1023, 2);
    wait_valid(ok);
    n_tests++;
    if (!ok || toa_data !== 17'd129023 || toa_err !== 1'b0) begin
      n_fail++;
      $display("FAIL max_toa: ok=%b d=%0d e=%b want 129023 0",
               ok, toa_data, toa_err);
    end
  endtask

  task automatic test_err();
    bit ok;
    int c1;
    int c2;
    do_reset();
    c1 = int'($urandom_range(1023, 0));
    c2 = int'($urandom_range(1023, 0));
    strobe(7'b0_111111, c1, 1);
    wait_valid(ok);
    n_tests++;
    if (!ok || toa_err !== 1'b1 || toa_data !== 17'(c1 * 126)) begin
      n_fail++;
      $display("FAIL err_pos63: ok=%b d=%0d e=%b want %0d 1",
               ok, toa_data, toa_err, c1 * 126);
    end
    repeat (4) @(negedge clk);
    strobe(7'b0_000101, c2, 0);
    wait_valid(ok);
    n_tests++;
    if (!ok || toa_err !== 1'b1 || toa_data !== 17'(c2 * 126)) begin
      n_fail++;
      $display("FAIL err_level0: ok=%b d=%0d e=%b want %0d 1",
               ok, toa_data, toa_err, c2 * 126);
    end
    n_tests++;
    if (hit_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL err_hitcnt: got %0d want 2", hit_cnt);
    end
  endtask

  task automatic test_dead_time();
    int busy_cycles;
    do_reset();
    busy_cycles = 0;
    hit_strobe = 1'b1;
    fine_code = 7'd10;
    coarse_cnt = CW'(7);
    level = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    hit_strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    n_tests++;
    if (ovf_cnt !== 8'd3 || hit_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL dead_counts: ovf=%0d hit=%0d want 3 1",
               ovf_cnt, hit_cnt);
    end
    n_tests++;
    if (busy_cycles != DEAD_CYC) begin
      n_fail++;
      $display("FAIL dead_busy: busy cycles %0d want %0d",
               busy_cycles, DEAD_CYC);
    end
  endtask

  task automatic test_full_stall();
    logic [CW+7:0] exp_q[$];
    logic [CW+7:0] e;
    int c;
    bit stable;
    do_reset();
    toa_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c = int'($urandom_range(1023, 0));
      if (i < DEPTH)
        exp_q.push_back(ref_toa(7'(i + 1), c, 2));
      strobe(7'(i + 1), c, 2);
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (ovf_cnt !== 8'd2 || hit_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL full_counts: ovf=%0d hit=%0d want 2 4",
               ovf_cnt, hit_cnt);
    end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!toa_valid || {toa_err, toa_data} !== exp_q[0])
        stable = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL full_stall_hold: d=%0d v=%b want %0d",
               toa_data, toa_valid, exp_q[0][CW+6:0]);
    end
    toa_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (toa_valid !== 1'b1 || {toa_err, toa_data} !== e) begin
        n_fail++;
        $display("FAIL full_pop%0d: v=%b e=%b d=%0d want %b %0d",
                 i, toa_valid, toa_err, toa_data, e[CW+7],
                 e[CW+6:0]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (toa_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained: valid=%b want 0", toa_valid);
    end
  endtask

  task automatic test_async_reset();
    bit stale;
    do_reset();
    toa_ready = 1'b0;
    strobe(7'd3, 11, 1);
    repeat (4) @(negedge clk);
    strobe(7'd4, 12, 1);
    repeat (4) @(negedge clk);
    strobe(7'd5, 13, 1);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (toa_valid !== 1'b0 || hit_cnt !== 16'd0 ||
        ovf_cnt !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b h=%0d o=%0d b=%b want 0",
               toa_valid, hit_cnt, ovf_cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    toa_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (toa_valid) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL async_stale: valid seen after reset release");
    end
  endtask

  task automatic test_random();
    logic [CW+7:0] exp_q[$];
    logic [CW+7:0] e;
    logic [6:0] f;
    int last_acc;
    int n_acc;
    int n_drop;
    int c;
    int l;
    int bad_pops;
    do_reset();
    toa_ready = 1'b1;
    last_acc = -100;
    n_acc = 0;
    n_drop = 0;
    bad_pops = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (toa_valid) begin
        if (exp_q.size() == 0) begin
          bad_pops++;
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if ({toa_err, toa_data} !== e) begin
            n_fail++;
            $display("FAIL rand_entry: e=%b d=%0d want %b %0d",
                     toa_err, toa_data, e[CW+7], e[CW+6:0]);
          end
        end
      end
      hit_strobe = ($urandom_range(2, 0) == 0) && (cyc < 390);
      f = 7'($urandom);
      c = int'($urandom_range(1023, 0));
      l = int'($urandom_range(7, 0));
      fine_code = f;
      coarse_cnt = CW'(c);
      level = 3'(l);
      if (hit_strobe) begin
        if (cyc - last_acc > DEAD_CYC) begin
          last_acc = cyc;
          n_acc++;
          exp_q.push_back(ref_toa(f, c, l));
        end else begin
          n_drop++;
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (exp_q.size() != 0 || bad_pops != 0) begin
      n_fail++;
      $display("FAIL rand_leftover: missing %0d extra %0d want 0 0",
               exp_q.size(), bad_pops);
    end
    n_tests++;
    if (hit_cnt !== 16'(n_acc) || ovf_cnt !== 8'(n_drop)) begin
      n_fail++;
      $display("FAIL rand_counts: hit=%0d ovf=%0d want %0d %0d",
               hit_cnt, ovf_cnt, n_acc, n_drop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_err();
    test_dead_time();
    test_full_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
